// File: rtl/chesssoc_hex_scan_driver.sv
// Time-multiplexed, active-low 7-segment scan driver for a 4-digit common-anode display.
// The displayed value is latched once per scan frame so a digit never shows a half-updated word.
module chesssoc_hex_scan_driver #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] hex_value,
    input  logic        blank,
    input  logic        lzb_en,
    input  logic [3:0]  blink_mask,
    output logic [6:0]  seg_n,
    output logic [3:0]  an_n,
    output logic        frame_start
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BF_LAST  = BW'(BLINK_FRAMES - 1);

    logic [DW-1:0] div_cnt_reg;
    logic [1:0]    dig_reg;
    logic [15:0]   frame_val_reg;
    logic [BW-1:0] bf_cnt_reg;
    logic          blink_phase_reg;
    logic [6:0]    seg_n_reg;
    logic [3:0]    an_n_reg;
    logic          frame_start_reg;

    logic          tick;
    logic          frame_tick;
    logic [3:0]    lz_dark;
    logic [3:0]    digit_dark;
    logic [3:0]    cur_nibble;

    function automatic logic [6:0] font(input logic [3:0] nib);
        case (nib)
            4'h0: font = 7'h40;
            4'h1: font = 7'h79;
            4'h2: font = 7'h24;
            4'h3: font = 7'h30;
            4'h4: font = 7'h19;
            4'h5: font = 7'h12;
            4'h6: font = 7'h02;
            4'h7: font = 7'h78;
            4'h8: font = 7'h00;
            4'h9: font = 7'h10;
            4'hA: font = 7'h08;
            4'hB: font = 7'h03;
            4'hC: font = 7'h46;
            4'hD: font = 7'h21;
            4'hE: font = 7'h06;
            default: font = 7'h0E;
        endcase
    endfunction

    assign tick       = (div_cnt_reg == DIV_LAST);
    assign frame_tick = tick && (dig_reg == 2'd3);
    assign cur_nibble = frame_val_reg[{dig_reg, 2'b00} +: 4];

    // A digit is leading-zero blanked when it and every more significant nibble are zero.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dark
            if (gi == 0) begin : g_units
                assign lz_dark[gi] = 1'b0;
            end else begin : g_upper
                assign lz_dark[gi] = lzb_en && (frame_val_reg[15:4*gi] == '0);
            end
            assign digit_dark[gi] = blank | (blink_phase_reg & blink_mask[gi]) | lz_dark[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_reg     <= '0;
            dig_reg         <= 2'd0;
            frame_val_reg   <= 16'h0000;
            bf_cnt_reg      <= '0;
            blink_phase_reg <= 1'b0;
            seg_n_reg       <= 7'h7F;
            an_n_reg        <= 4'hF;
            frame_start_reg <= 1'b0;
        end else begin
            div_cnt_reg     <= tick ? '0 : div_cnt_reg + DW'(1);
            frame_start_reg <= frame_tick;
            if (tick) begin
                dig_reg <= dig_reg + 2'd1;
            end
            if (frame_tick) begin
                frame_val_reg <= hex_value;
                if (bf_cnt_reg == BF_LAST) begin
                    bf_cnt_reg      <= '0;
                    blink_phase_reg <= ~blink_phase_reg;
                end else begin
                    bf_cnt_reg <= bf_cnt_reg + BW'(1);
                end
            end
            // First cycle of every slot is forced dark so the previous digit cannot ghost.
            if (div_cnt_reg == '0 || digit_dark[dig_reg]) begin
                an_n_reg  <= 4'hF;
                seg_n_reg <= 7'h7F;
            end else begin
                an_n_reg  <= ~(4'b0001 << dig_reg);
                seg_n_reg <= font(cur_nibble);
            end
        end
    end

    assign seg_n       = seg_n_reg;
    assign an_n        = an_n_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_chesssoc_hex_scan_driver.sv
// Directed scoreboard bench: expected outputs are derived from the cycle count since reset.
module tb_chesssoc_hex_scan_driver;

    localparam int SD = 4;
    localparam int BF = 2;

    logic        clk;
    logic        reset;
    logic [15:0] hex_value;
    logic        blank;
    logic        lzb_en;
    logic [3:0]  blink_mask;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        frame_start;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fs;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          k;        // clock edges since reset release
    int          nl;       // frame latches so far
    logic [15:0] fv;       // value the display should currently be holding

    localparam logic [6:0] FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    chesssoc_hex_scan_driver #(
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hex_value   (hex_value),
        .blank       (blank),
        .lzb_en      (lzb_en),
        .blink_mask  (blink_mask),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, expv);
        end
    endtask

    // Predict the outputs after the coming edge, apply the edge, then compare.
    task automatic step(input logic rst);
        exp_t       e;
        exp_t       got;
        int         d;
        logic [3:0] nib;
        logic       dk;
        reset = rst;
        if (rst) begin
            e  = '{an: 4'hF, seg: 7'h7F, fs: 1'b0};
            k  = 0;
            nl = 0;
            fv = 16'h0000;
        end else begin
            d   = (k / SD) % 4;
            nib = 4'(fv >> (4 * d));
            dk  = blank || ((((nl / BF) % 2) == 1) && blink_mask[d])
                  || (lzb_en && d >= 1 && ((fv >> (4 * d)) == 16'h0000));
            if ((k % SD) == 0 || dk) begin
                e.an  = 4'hF;
                e.seg = 7'h7F;
            end else begin
                e.an  = ~(4'b0001 << d);
                e.seg = FONT[nib];
            end
            e.fs = (((k + 1) % (4 * SD)) == 0);
            if (e.fs) begin
                fv = hex_value;
                nl++;
            end
            k++;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        $display("k=%0d rst=%0b hex=%h an_n=%h seg_n=%h fs=%0b", k, rst, hex_value, an_n, seg_n, frame_start);
        check("an_n", {12'h0, an_n}, {12'h0, got.an});
        check("seg_n", {9'h0, seg_n}, {9'h0, got.seg});
        check("frame_start", {15'h0, frame_start}, {15'h0, got.fs});
    endtask

    task automatic run_to(input int target);
        while (k < target) step(1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        hex_value  = 16'h1234;
        blank      = 1'b0;
        lzb_en     = 1'b0;
        blink_mask = 4'b0000;
        k = 0; nl = 0; fv = 16'h0000;

        repeat (3) step(1'b1);
        check("reset_an", {12'h0, an_n}, 16'h000F);
        check("reset_seg", {9'h0, seg_n}, 16'h007F);
        check("reset_fs", {15'h0, frame_start}, 16'h0000);

        // Basic scan of 1234.
        run_to(16);
        check("first_latch_fs", {15'h0, frame_start}, 16'h0001);
        run_to(18);
        check("d0_1234_an", {12'h0, an_n}, 16'h000E);
        check("d0_1234_seg", {9'h0, seg_n}, 16'h0019);

        // Mid-frame change must wait for the boundary.
        run_to(40);
        hex_value = 16'hABCD;
        run_to(48);
        check("abcd_latch_fs", {15'h0, frame_start}, 16'h0001);
        run_to(50);
        check("d0_abcd_seg", {9'h0, seg_n}, 16'h0021);

        // Leading-zero blanking.
        lzb_en    = 1'b1;
        hex_value = 16'h0040;
        run_to(70);
        check("lzb_d1_seg", {9'h0, seg_n}, 16'h0019);
        run_to(74);
        check("lzb_d2_an", {12'h0, an_n}, 16'h000F);
        hex_value = 16'h0000;
        run_to(82);
        check("lzb0_d0_seg", {9'h0, seg_n}, 16'h0040);
        run_to(86);
        check("lzb0_d1_an", {12'h0, an_n}, 16'h000F);

        // Blinking on digit 2 over several frames.
        lzb_en     = 1'b0;
        hex_value  = 16'h5678;
        blink_mask = 4'b0100;
        run_to(170);

        // Global blank for 10 cycles mid-slot.
        blank = 1'b1;
        repeat (10) step(1'b0);
        check("blank_an", {12'h0, an_n}, 16'h000F);
        blank = 1'b0;
        repeat (20) step(1'b0);

        // Reset one cycle before a frame boundary.
        while (((k + 1) % (4 * SD)) != 0) step(1'b0);
        step(1'b1);
        repeat (4 * SD) step(1'b0);
        check("post_reset_latch_fs", {15'h0, frame_start}, 16'h0001);
        repeat (24) step(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
